// File: rtl/mdio_peripheral_if.sv
// Register-bank side of the MDIO peripheral: frame address, write strobe/payload
// and read request/return data.
interface mdio_peripheral_if;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        rd_stb;
    logic [15:0] rd_data;

    modport master (
        output addr,
        output wr_data,
        output wr_stb,
        output rd_stb,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_data,
        input  wr_stb,
        input  rd_stb,
        output rd_data
    );
endinterface

// File: rtl/mdio_peripheral.sv
// PHY-side MDIO slave: decodes 32-bit clause-22 frames from the controller into
// register-bank writes and serves reads by driving the data phase back on MDIO.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'd6,
    parameter int         PRE_MIN  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mdio_i,
    output logic               mdio_o,
    output logic               mdio_oe,
    output logic               frame_err,
    mdio_peripheral_if.master  bus
);

    localparam int PW = (PRE_MIN > 0) ? $clog2(PRE_MIN + 1) : 1;
    localparam logic [PW-1:0] PRE_SAT = PW'(PRE_MIN);

    typedef enum logic [2:0] {
        IDLE,
        START,
        HEADER,
        TA_WR,
        DATA_WR,
        TA_RD,
        DATA_RD,
        SKIP
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [PW-1:0] pre_cnt, pre_cnt_nxt;
    logic [16:0]   shift_q;
    logic [17:0]   frame_bits;
    logic [15:0]   rd_shift, rd_shift_nxt;
    logic [4:0]    addr_q, addr_nxt;
    logic [15:0]   wr_data_q, wr_data_nxt;
    logic          wr_stb_q, wr_stb_nxt;
    logic          rd_stb_q, rd_stb_nxt;
    logic          mdio_o_q, mdio_o_nxt;
    logic          mdio_oe_q, mdio_oe_nxt;
    logic          frame_err_q, frame_err_nxt;

    // Last 18 sampled bits including the one on the line now; at the bit 18 edge
    // [11:0] holds OP/PHYAD/REGAD, at the bit 0 edge it holds TA and DATA.
    assign frame_bits = {shift_q, mdio_i};

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt - 5'd1;
        pre_cnt_nxt   = '0;
        rd_shift_nxt  = rd_shift;
        addr_nxt      = addr_q;
        wr_data_nxt   = wr_data_q;
        wr_stb_nxt    = 1'b0;
        rd_stb_nxt    = 1'b0;
        mdio_o_nxt    = 1'b0;
        mdio_oe_nxt   = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (mdio_i) begin
                    pre_cnt_nxt = (pre_cnt == PRE_SAT) ? pre_cnt : pre_cnt + 1'b1;
                end else if (pre_cnt == PRE_SAT) begin
                    state_nxt = START;
                end
            end

            START: begin
                bit_cnt_nxt = '0;
                if (mdio_i) begin
                    state_nxt   = HEADER;
                    bit_cnt_nxt = 5'd29;
                end
            end

            HEADER: begin
                if (bit_cnt == 5'd18) begin
                    bit_cnt_nxt = 5'd17;
                    if (frame_bits[9:5] != PHY_ADDR) begin
                        state_nxt = SKIP;
                    end else if (frame_bits[11:10] == 2'b01) begin
                        addr_nxt  = frame_bits[4:0];
                        state_nxt = TA_WR;
                    end else if (frame_bits[11:10] == 2'b10) begin
                        addr_nxt   = frame_bits[4:0];
                        rd_stb_nxt = 1'b1;
                        state_nxt  = TA_RD;
                    end else begin
                        state_nxt = SKIP;
                    end
                end
            end

            TA_WR: begin
                if (bit_cnt == 5'd16) begin
                    state_nxt   = DATA_WR;
                    bit_cnt_nxt = 5'd15;
                end
            end

            DATA_WR: begin
                if (bit_cnt == 5'd0) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                    if (frame_bits[17:16] == 2'b10) begin
                        wr_data_nxt = frame_bits[15:0];
                        wr_stb_nxt  = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end

            // Bit 17 cycle: controller still releasing the line, bank presents rd_data.
            TA_RD: begin
                mdio_oe_nxt = 1'b1;
                if (bit_cnt == 5'd17) begin
                    rd_shift_nxt = bus.rd_data;
                end else begin
                    state_nxt    = DATA_RD;
                    bit_cnt_nxt  = 5'd15;
                    mdio_o_nxt   = rd_shift[15];
                    rd_shift_nxt = {rd_shift[14:0], 1'b0};
                end
            end

            DATA_RD: begin
                if (bit_cnt == 5'd0) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end else begin
                    mdio_oe_nxt  = 1'b1;
                    mdio_o_nxt   = rd_shift[15];
                    rd_shift_nxt = {rd_shift[14:0], 1'b0};
                end
            end

            SKIP: begin
                if (bit_cnt == 5'd0) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end
            end

            default: begin
                state_nxt   = IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            pre_cnt     <= '0;
            shift_q     <= '0;
            rd_shift    <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            pre_cnt     <= pre_cnt_nxt;
            shift_q     <= frame_bits[16:0];
            rd_shift    <= rd_shift_nxt;
            addr_q      <= addr_nxt;
            wr_data_q   <= wr_data_nxt;
            wr_stb_q    <= wr_stb_nxt;
            rd_stb_q    <= rd_stb_nxt;
            mdio_o_q    <= mdio_o_nxt;
            mdio_oe_q   <= mdio_oe_nxt;
            frame_err_q <= frame_err_nxt;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_stb  = wr_stb_q;
    assign bus.rd_stb  = rd_stb_q;
    assign mdio_o      = mdio_o_q;
    assign mdio_oe     = mdio_oe_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Bench for mdio_peripheral: frame-level reference model scheduled into per-cycle
// expectations, directed frames with literal checks, randomized frames, preamble check.
module tb_mdio_peripheral;

    localparam int MAXC = 4096;

    logic clk;
    logic reset;
    logic mdio_a, mdio_b;
    logic mdio_o_a, mdio_oe_a, frame_err_a;
    logic mdio_o_b, mdio_oe_b, frame_err_b;

    mdio_peripheral_if bus_a ();
    mdio_peripheral_if bus_b ();

    mdio_peripheral #(.PHY_ADDR(5'd6), .PRE_MIN(0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .mdio_i    (mdio_a),
        .mdio_o    (mdio_o_a),
        .mdio_oe   (mdio_oe_a),
        .frame_err (frame_err_a),
        .bus       (bus_a)
    );

    mdio_peripheral #(.PHY_ADDR(5'd6), .PRE_MIN(32)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .mdio_i    (mdio_b),
        .mdio_o    (mdio_o_b),
        .mdio_oe   (mdio_oe_b),
        .frame_err (frame_err_b),
        .bus       (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus and expectation timeline, indexed by clk period.
    logic        bit_a [MAXC];
    logic        bit_b [MAXC];
    logic        rst_v [MAXC];
    logic [15:0] rdd   [MAXC];
    logic        e_wr  [MAXC];
    logic        e_rd  [MAXC];
    logic        e_err [MAXC];
    logic        e_oe  [MAXC];
    logic        e_o   [MAXC];
    logic        a_ev  [MAXC];
    logic [4:0]  a_val [MAXC];
    logic        w_ev  [MAXC];
    logic [15:0] w_val [MAXC];

    int len;
    int played;
    int pb;
    int checks;
    int passes;
    logic        cmp_en;
    logic [31:0] exp_vec;
    logic [4:0]  hold_addr;
    logic [15:0] hold_wd;

    int          n_wr, n_rd, n_err, n_oe, n_wr_b, n_other_b;
    logic [15:0] last_wd, last_wd_b;
    logic [4:0]  rd_addr;
    logic [16:0] o_seq;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] make_frame(input logic [1:0] op, input logic [4:0] phy,
                                               input logic [4:0] rega, input logic [1:0] ta,
                                               input logic [15:0] d);
        return {2'b01, op, phy, rega, ta, d};
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            bit_a[len] = 1'b1;
            rst_v[len] = 1'b1;
            rdd[len]   = 16'($urandom);
            len++;
        end
    endtask

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++) begin
            bit_a[len] = 1'b1;
            rst_v[len] = 1'b0;
            rdd[len]   = 16'($urandom);
            len++;
        end
    endtask

    // Frame starting at cycle s: bit b is on the line in cycle s+31-b. A reset
    // planted at bit `trunc` abandons the frame; effects after that edge are dropped.
    task automatic add_frame(input logic [31:0] w, input logic [15:0] rv, input int trunc);
        int s;
        int c;
        int lim;
        s   = len;
        lim = MAXC - 1;
        for (int b = 31; b >= 0; b--) begin
            c        = s + 31 - b;
            bit_a[c] = w[b];
            rst_v[c] = 1'b1;
            rdd[c]   = (b == 17) ? rv : 16'($urandom);
            if (b == trunc) begin
                rst_v[c] = 1'b0;
                lim      = c;
                break;
            end
        end
        len = (lim < MAXC - 1) ? lim + 1 : s + 32;
        if (w[27:23] == 5'd6 && (w[29:28] == 2'b01 || w[29:28] == 2'b10)) begin
            if (s + 14 <= lim) begin
                a_ev[s+14]  = 1'b1;
                a_val[s+14] = w[22:18];
            end
            if (w[29:28] == 2'b01) begin
                if (s + 32 <= lim) begin
                    if (w[17:16] == 2'b10) begin
                        e_wr[s+32]  = 1'b1;
                        w_ev[s+32]  = 1'b1;
                        w_val[s+32] = w[15:0];
                    end else begin
                        e_err[s+32] = 1'b1;
                    end
                end
            end else begin
                if (s + 14 <= lim) e_rd[s+14] = 1'b1;
                for (int k = 0; k < 17; k++) begin
                    if (s + 15 + k <= lim) begin
                        e_oe[s+15+k] = 1'b1;
                        e_o[s+15+k]  = (k == 0) ? 1'b0 : rv[16-k];
                    end
                end
            end
        end
    endtask

    task automatic put_b(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            bit_b[pb] = v;
            pb++;
        end
    endtask

    task automatic put_b_frame(input logic [31:0] w);
        for (int b = 31; b >= 0; b--) begin
            bit_b[pb] = w[b];
            pb++;
        end
    endtask

    // Plays every scheduled cycle not yet driven; held outputs follow the event list.
    task automatic apply_stimulus();
        while (played < len) begin
            reset         = rst_v[played];
            mdio_a        = bit_a[played];
            mdio_b        = bit_b[played];
            bus_a.rd_data = rdd[played];
            bus_b.rd_data = rdd[played];
            if (played == 0) begin
                hold_addr = '0;
                hold_wd   = '0;
            end else if (!rst_v[played-1]) begin
                hold_addr = '0;
                hold_wd   = '0;
            end
            if (a_ev[played]) hold_addr = a_val[played];
            if (w_ev[played]) hold_wd = w_val[played];
            exp_vec = {6'd0, hold_addr, hold_wd, e_wr[played], e_rd[played],
                       e_o[played], e_oe[played], e_err[played]};
            cmp_en = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            played++;
        end
        cmp_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output($sformatf("cycle_%0d", played),
                         {6'd0, bus_a.addr, bus_a.wr_data, bus_a.wr_stb, bus_a.rd_stb,
                          mdio_o_a, mdio_oe_a, frame_err_a}, exp_vec);
            if (bus_a.wr_stb === 1'b1) begin
                n_wr++;
                last_wd = bus_a.wr_data;
            end
            if (bus_a.rd_stb === 1'b1) begin
                n_rd++;
                rd_addr = bus_a.addr;
            end
            if (frame_err_a === 1'b1) n_err++;
            if (mdio_oe_a === 1'b1) begin
                n_oe++;
                o_seq = {o_seq[15:0], mdio_o_a};
            end
            if (bus_b.wr_stb === 1'b1) begin
                n_wr_b++;
                last_wd_b = bus_b.wr_data;
            end
            if (bus_b.rd_stb !== 1'b0 || mdio_oe_b !== 1'b0 || frame_err_b !== 1'b0 || mdio_o_b !== 1'b0)
                n_other_b++;
        end
    end

    initial begin
        int s_wr, s_rd, s_err, s_oe, s_wb;
        logic [31:0] w;
        checks = 0;  passes = 0;  len = 0;  played = 0;  cmp_en = 1'b0;
        n_wr = 0;  n_rd = 0;  n_err = 0;  n_oe = 0;  n_wr_b = 0;  n_other_b = 0;
        last_wd = '0;  last_wd_b = '0;  rd_addr = '0;  o_seq = '0;
        exp_vec = '0;  hold_addr = '0;  hold_wd = '0;
        for (int c = 0; c < MAXC; c++) begin
            bit_a[c] = 1'b1;  bit_b[c] = 1'b0;  rst_v[c] = 1'b1;  rdd[c] = '0;
            e_wr[c] = 1'b0;  e_rd[c] = 1'b0;  e_err[c] = 1'b0;  e_oe[c] = 1'b0;  e_o[c] = 1'b0;
            a_ev[c] = 1'b0;  a_val[c] = '0;  w_ev[c] = 1'b0;  w_val[c] = '0;
        end
        reset = 1'b0;  mdio_a = 1'b1;  mdio_b = 1'b0;
        bus_a.rd_data = '0;  bus_b.rd_data = '0;
        @(posedge clk);
        #1;

        add_reset(4);
        add_idle(2);
        apply_stimulus();
        check_output("reset_outputs",
                     {6'd0, bus_a.addr, bus_a.wr_data, bus_a.wr_stb, bus_a.rd_stb,
                      mdio_o_a, mdio_oe_a, frame_err_a}, 32'd0);

        // Write to PHY 6, REGAD 0x1B, data 0xA5C3
        s_wr = n_wr;  s_rd = n_rd;  s_oe = n_oe;
        add_frame(make_frame(2'b01, 5'd6, 5'h1B, 2'b10, 16'hA5C3), 16'h0, -1);
        add_idle(2);
        apply_stimulus();
        check_output("wr_stb_count", 32'(n_wr - s_wr), 32'd1);
        check_output("wr_data", {16'd0, last_wd}, 32'h0000_A5C3);
        check_output("wr_addr", {27'd0, bus_a.addr}, 32'h1B);
        check_output("wr_no_rd_oe", 32'(n_rd - s_rd + n_oe - s_oe), 32'd0);

        // Read of REGAD 0x1B returning 0xBEEF
        s_rd = n_rd;  s_oe = n_oe;
        add_frame(32'h636E746E, 16'hBEEF, -1);
        add_idle(2);
        apply_stimulus();
        check_output("rd_stb_count", 32'(n_rd - s_rd), 32'd1);
        check_output("rd_addr", {27'd0, rd_addr}, 32'h1B);
        check_output("oe_cycles", 32'(n_oe - s_oe), 32'd17);
        check_output("mdio_o_seq", {15'd0, o_seq}, 32'h0000_BEEF);

        // Foreign PHY immediately followed by a valid write
        s_wr = n_wr;
        add_frame(make_frame(2'b01, 5'd5, 5'h1B, 2'b10, 16'hAAAA), 16'h0, -1);
        add_frame(make_frame(2'b01, 5'd6, 5'h03, 2'b10, 16'h1234), 16'h0, -1);
        add_idle(2);
        apply_stimulus();
        check_output("b2b_wr_count", 32'(n_wr - s_wr), 32'd1);
        check_output("b2b_wr_data", {16'd0, last_wd}, 32'h1234);

        // Bad turnaround
        s_wr = n_wr;  s_err = n_err;
        add_frame(make_frame(2'b01, 5'd6, 5'h1C, 2'b11, 16'h5555), 16'h0, -1);
        add_idle(2);
        apply_stimulus();
        check_output("ta_err_count", 32'(n_err - s_err), 32'd1);
        check_output("ta_err_no_wr", 32'(n_wr - s_wr), 32'd0);
        check_output("ta_err_wr_data", {16'd0, bus_a.wr_data}, 32'h1234);

        // Reset during bit 8, then a clean write
        s_wr = n_wr;
        add_frame(make_frame(2'b01, 5'd6, 5'h04, 2'b10, 16'h7777), 16'h0, 8);
        add_idle(3);
        apply_stimulus();
        check_output("rst_mid_no_wr", 32'(n_wr - s_wr), 32'd0);
        check_output("rst_mid_regs", {11'd0, bus_a.addr, bus_a.wr_data}, 32'd0);
        add_frame(make_frame(2'b01, 5'd6, 5'h09, 2'b10, 16'h0F0F), 16'h0, -1);
        add_idle(2);
        apply_stimulus();
        check_output("post_rst_wr_count", 32'(n_wr - s_wr), 32'd1);
        check_output("post_rst_wr_data", {16'd0, last_wd}, 32'h0F0F);

        // Randomized traffic: mixed ops, foreign PHYs, bad TAs, occasional resets
        for (int i = 0; i < 60; i++) begin
            add_idle($urandom_range(0, 3));
            w = make_frame(2'($urandom),
                           ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd6,
                           5'($urandom),
                           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10,
                           16'($urandom));
            add_frame(w, 16'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1);
        end
        add_idle(2);
        apply_stimulus();

        // Preamble-checking instance: 31 ones rejected, 32 ones accepted
        s_wb = n_wr_b;
        pb = len;
        put_b(1'b0, 3);
        put_b(1'b1, 31);
        put_b_frame(make_frame(2'b01, 5'd6, 5'h1B, 2'b10, 16'hC0DE));
        put_b(1'b0, 2);
        add_idle(pb - len);
        apply_stimulus();
        check_output("pre31_no_wr", 32'(n_wr_b - s_wb), 32'd0);
        pb = len;
        put_b(1'b1, 32);
        put_b_frame(make_frame(2'b01, 5'd6, 5'h1B, 2'b10, 16'hFACE));
        put_b(1'b0, 2);
        add_idle(pb - len);
        apply_stimulus();
        check_output("pre32_wr_count", 32'(n_wr_b - s_wb), 32'd1);
        check_output("pre32_wr_data", {16'd0, last_wd_b}, 32'h0000_FACE);
        check_output("pre32_addr", {27'd0, bus_b.addr}, 32'h1B);
        check_output("pre_inst_quiet", 32'(n_other_b), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
